// File: rtl/arb_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_ram_pkg
// Purpose  : Shared types and helpers for the arbitrated shared RAM.
//            rr_pick2 picks up to two requesters by round-robin scan.
//            byte_merge combines two words under a byte-enable mask.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package arb_ram_pkg;

  // Helpers are sized for the largest supported configuration (8 channels,
  // 64-bit words); callers zero-extend narrower vectors.
  localparam int MAX_CH        = 8;
  localparam int WIDTH_DEFAULT = 32;
  localparam int BYTES         = WIDTH_DEFAULT / 8;

  typedef struct packed {
    logic [MAX_CH-1:0] gnt;    // one-hot-or-two grant vector
    logic              a_vld;  // port A has a grantee
    logic [2:0]        a_idx;  // port A channel
    logic              b_vld;  // port B has a grantee
    logic [2:0]        b_idx;  // port B channel
  } pick2_t;

  // Scan channels ptr, ptr+1, ... (mod n); the first valid one lands on
  // port A, the second on port B.
  function automatic pick2_t rr_pick2(input logic [MAX_CH-1:0] valid,
                                      input logic [2:0]        ptr,
                                      input int                n);
    pick2_t     r;
    logic [2:0] idx;
    r = '0;
    for (int k = 0; k < MAX_CH; k++) begin
      if (k < n) begin
        idx = 3'((int'(ptr) + k) % n);
        if (valid[idx]) begin
          if (!r.a_vld) begin
            r.a_vld    = 1'b1;
            r.a_idx    = idx;
            r.gnt[idx] = 1'b1;
          end else if (!r.b_vld) begin
            r.b_vld    = 1'b1;
            r.b_idx    = idx;
            r.gnt[idx] = 1'b1;
          end
        end
      end
    end
    return r;
  endfunction

  // Take bytes from new_w where be=1, keep old_w elsewhere.
  function automatic logic [63:0] byte_merge(input logic [63:0] old_w,
                                             input logic [63:0] new_w,
                                             input logic [7:0]  be);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) begin
      r[j*8 +: 8] = be[j] ? new_w[j*8 +: 8] : old_w[j*8 +: 8];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_ram_ram_core.sv
`default_nettype none
// ============================================================================
// Module   : ram_core
// Purpose  : Two-port RAM array, per-byte write enables, one-cycle
//            synchronous read, read-during-write returns old data.
// Ports    : clk; per port x in {a,b}: en_x, we_x, addr_x, wdata_x, be_x
//            (request), rdata_x (read data, valid the cycle after a read)
// Revision : 1.0 - initial release
// ============================================================================
module ram_core #(
  parameter int WIDTHAD = 16,
  parameter int WIDTH   = 32
) (
  input  logic               clk,
  input  logic               en_a,
  input  logic               we_a,
  input  logic [WIDTHAD-1:0] addr_a,
  input  logic [WIDTH-1:0]   wdata_a,
  input  logic [WIDTH/8-1:0] be_a,
  output logic [WIDTH-1:0]   rdata_a,
  input  logic               en_b,
  input  logic               we_b,
  input  logic [WIDTHAD-1:0] addr_b,
  input  logic [WIDTH-1:0]   wdata_b,
  input  logic [WIDTH/8-1:0] be_b,
  output logic [WIDTH-1:0]   rdata_b
);

  localparam int NB    = WIDTH / 8;
  localparam int DEPTH = 1 << WIDTHAD;

  logic [WIDTH-1:0] mem [DEPTH];

  // Non-blocking reads sample the array before this edge's writes land,
  // which gives old-data behaviour across ports. The arbiter never issues
  // two writes to one address in the same cycle.
  always_ff @(posedge clk) begin
    if (en_a && we_a) begin
      for (int j = 0; j < NB; j++) begin
        if (be_a[j]) mem[addr_a][j*8 +: 8] <= wdata_a[j*8 +: 8];
      end
    end
    if (en_b && we_b) begin
      for (int j = 0; j < NB; j++) begin
        if (be_b[j]) mem[addr_b][j*8 +: 8] <= wdata_b[j*8 +: 8];
      end
    end
    if (en_a && !we_a) rdata_a <= mem[addr_a];
    if (en_b && !we_b) rdata_b <= mem[addr_b];
  end

endmodule
`default_nettype wire

// File: rtl/arb_ram.sv
`default_nettype none
// ============================================================================
// Module   : arb_ram
// Purpose  : Shared RAM serving CHANNELS requesters through two RAM ports
//            with a round-robin two-grant arbiter and a per-channel
//            read-response demux.
// Ports    : clk, rst_n (async, active low)
//            req_valid/req_ready/req_we/req_addr/req_wdata/req_be (per
//            channel request, packed), rsp_valid/rsp_rdata (per channel
//            read response, packed)
// Revision : 1.0 - initial release
// ============================================================================
module arb_ram
  import arb_ram_pkg::*;
#(
  parameter int WIDTHAD  = 16,
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int OUT_REG  = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CHANNELS-1:0]           req_valid,
  output logic [CHANNELS-1:0]           req_ready,
  input  logic [CHANNELS-1:0]           req_we,
  input  logic [CHANNELS*WIDTHAD-1:0]   req_addr,
  input  logic [CHANNELS*WIDTH-1:0]     req_wdata,
  input  logic [CHANNELS*(WIDTH/8)-1:0] req_be,
  output logic [CHANNELS-1:0]           rsp_valid,
  output logic [CHANNELS*WIDTH-1:0]     rsp_rdata
);

  localparam int NB = WIDTH / 8;

  logic [2:0]         ptr, ptr_nxt, last;
  logic [MAX_CH-1:0]  v8;
  pick2_t             pick;
  logic               b_ok;
  logic               we_a, we_b;
  logic [WIDTHAD-1:0] addr_a, addr_b;
  logic [WIDTH-1:0]   wdata_a, wdata_b, rdata_a, rdata_b;
  logic [NB-1:0]      be_a, be_b;

  // Arbiter: pick two, steer the grantees' fields onto the ports, drop
  // port B on a same-address double write.
  always_comb begin
    v8 = '0;
    v8[CHANNELS-1:0] = req_valid & {CHANNELS{rst_n}};
    pick    = rr_pick2(v8, ptr, CHANNELS);
    we_a    = 1'b0;
    we_b    = 1'b0;
    addr_a  = '0;
    addr_b  = '0;
    wdata_a = '0;
    wdata_b = '0;
    be_a    = '0;
    be_b    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (pick.a_idx == 3'(c)) begin
        we_a    = req_we[c];
        addr_a  = req_addr[c*WIDTHAD +: WIDTHAD];
        wdata_a = req_wdata[c*WIDTH +: WIDTH];
        be_a    = req_be[c*NB +: NB];
      end
      if (pick.b_idx == 3'(c)) begin
        we_b    = req_we[c];
        addr_b  = req_addr[c*WIDTHAD +: WIDTHAD];
        wdata_b = req_wdata[c*WIDTH +: WIDTH];
        be_b    = req_be[c*NB +: NB];
      end
    end
    b_ok = pick.b_vld && !(pick.a_vld && we_a && we_b && (addr_a == addr_b));
    for (int c = 0; c < CHANNELS; c++) begin
      req_ready[c] = (pick.a_vld && pick.a_idx == 3'(c)) ||
                     (b_ok && pick.b_idx == 3'(c));
    end
    // A deferred port-B channel sits right after port A, so moving the
    // pointer past the last actual grantee gives it first pick next time.
    last    = b_ok ? pick.b_idx : pick.a_idx;
    ptr_nxt = (|pick.gnt) ? 3'((int'(last) + 1) % CHANNELS) : ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_nxt;
  end

  ram_core #(.WIDTHAD(WIDTHAD), .WIDTH(WIDTH)) u_ram (
    .clk    (clk),
    .en_a   (pick.a_vld),
    .we_a   (we_a),
    .addr_a (addr_a),
    .wdata_a(wdata_a),
    .be_a   (be_a),
    .rdata_a(rdata_a),
    .en_b   (b_ok),
    .we_b   (we_b),
    .addr_b (addr_b),
    .wdata_b(wdata_b),
    .be_b   (be_b),
    .rdata_b(rdata_b)
  );

  // Channel-ID tracking for reads in flight through the RAM stage.
  logic       s1_vld_a, s1_vld_b;
  logic [2:0] s1_id_a, s1_id_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_a <= 1'b0;
      s1_vld_b <= 1'b0;
      s1_id_a  <= '0;
      s1_id_b  <= '0;
    end else begin
      s1_vld_a <= pick.a_vld && !we_a;
      s1_vld_b <= b_ok && !we_b;
      s1_id_a  <= pick.a_idx;
      s1_id_b  <= pick.b_idx;
    end
  end

  // Ports always serve distinct channels, so at most one hits per channel.
  logic [CHANNELS-1:0] hit;
  logic [WIDTH-1:0]    dat [CHANNELS];

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      hit[c] = (s1_vld_a && s1_id_a == 3'(c)) || (s1_vld_b && s1_id_b == 3'(c));
      dat[c] = (s1_vld_a && s1_id_a == 3'(c)) ? rdata_a : rdata_b;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [CHANNELS-1:0] vld_q;
      logic [WIDTH-1:0]    dat_q [CHANNELS];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
          for (int c = 0; c < CHANNELS; c++) dat_q[c] <= '0;
        end else begin
          vld_q <= hit;
          for (int c = 0; c < CHANNELS; c++) begin
            if (hit[c]) dat_q[c] <= dat[c];
          end
        end
      end

      always_comb begin
        rsp_valid = vld_q;
        for (int c = 0; c < CHANNELS; c++) rsp_rdata[c*WIDTH +: WIDTH] = dat_q[c];
      end
    end else begin : g_out_comb
      // Pass RAM data straight through on a hit; hold the last value after.
      logic [WIDTH-1:0] held [CHANNELS];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int c = 0; c < CHANNELS; c++) held[c] <= '0;
        end else begin
          for (int c = 0; c < CHANNELS; c++) begin
            if (hit[c]) held[c] <= dat[c];
          end
        end
      end

      always_comb begin
        rsp_valid = hit;
        for (int c = 0; c < CHANNELS; c++) begin
          rsp_rdata[c*WIDTH +: WIDTH] = hit[c] ? dat[c] : held[c];
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire
